// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, STATUS layout, reset values.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package mmio_pkg;

  localparam int DATA_W = 16;
  localparam int LED_W  = 10;
  localparam int SW_W   = 10;

  // Word offsets inside the 16-word I/O window
  localparam logic [3:0] MMIO_LED    = 4'h0;
  localparam logic [3:0] MMIO_SW     = 4'h1;
  localparam logic [3:0] MMIO_TCOUNT = 4'h2;
  localparam logic [3:0] MMIO_TCMP   = 4'h3;
  localparam logic [3:0] MMIO_STATUS = 4'h4;
  localparam logic [3:0] MMIO_TXDATA = 4'h5;

  // STATUS bit positions
  localparam int ST_MATCH  = 0;
  localparam int ST_OVF    = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_EMPTY  = 3;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 7;

  // Compare register starts at all-ones so the match flag stays quiet after reset
  localparam logic [DATA_W-1:0] TCMP_RST = 16'hFFFF;

  // STATUS word; field order mirrors the bit positions above
  typedef struct packed {
    logic [7:0] rsvd;
    logic [3:0] cnt;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       match;
  } status_t;

  // True when the address falls in the 16-word window starting at base
  function automatic logic in_window(input logic [DATA_W-1:0] addr,
                                     input logic [DATA_W-1:0] base);
    return addr[DATA_W-1:4] == base[DATA_W-1:4];
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// CPU data-port bundle between the control FSM (master) and the MMIO responder (slave).
// Latency: hit is combinational; rd_data/rd_hit are registered one cycle after re.
// Backpressure: none; every strobe is accepted in the cycle it is sampled.
interface mmio_responder_if;
  import mmio_pkg::*;

  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              we;
  logic              re;
  logic              hit;
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;

  modport master (
    output addr, wr_data, we, re,
    input  hit, rd_data, rd_hit
  );

  modport slave (
    input  addr, wr_data, we, re,
    output hit, rd_data, rd_hit
  );

endinterface

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; head is read straight from the storage flops.
// Latency: a push is visible at the head one cycle later; a pop advances the head one cycle later.
// Backpressure: pop is evaluated before push, so a full FIFO accepts a push when popped in the same cycle; otherwise the push is dropped and flagged.
module mmio_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push is about to use
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target on CPU port A: LED reg, synced switches, prescaled timer with sticky match, TX FIFO; timer built only with MMIO_TIMER_EN defined.
// Latency: hit combinational; loads return 1 cycle after re (BRAM-matched); stores commit at the sampling edge.
// Backpressure: CPU side never stalls; TX drains on tx_valid & tx_ready, pushes into a full FIFO without a pop are dropped and set overflow.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PRESCALE   = 50000
) (
  input  logic              clk,
  input  logic              reset,
  mmio_responder_if.slave   bus,
  input  logic [SW_W-1:0]   switches,
  output logic [LED_W-1:0]  leds,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [3:0]        offset;
  logic              wr_stb;
  logic              rd_stb;
  logic              stat_clr;
  logic [LED_W-1:0]  led_reg;
  logic [SW_W-1:0]   sw_s1;
  logic [SW_W-1:0]   sw_s2;
  logic              ovf;
  logic              match;
  logic              match_set;
  logic [DATA_W-1:0] tcount_rd;
  logic [DATA_W-1:0] tcmp_rd;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [4:0]        fifo_count_ext;
  logic              fifo_drop;
  status_t           status;
  logic [DATA_W-1:0] rd_val;

  assign bus.hit   = in_window(bus.addr, BASE_ADDR);
  assign offset    = bus.addr[3:0];
  assign wr_stb    = bus.we & bus.hit;
  assign rd_stb    = bus.re & bus.hit;
  assign stat_clr  = rd_stb & (offset == MMIO_STATUS);
  assign fifo_push = wr_stb & (offset == MMIO_TXDATA);
  assign leds      = led_reg;
  assign tx_valid  = ~fifo_empty;

`ifdef MMIO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]     presc;
  logic [DATA_W-1:0] tcount;
  logic [DATA_W-1:0] tcmp;
  logic              tick;
  logic              tcount_wr;
  logic              tcmp_wr;

  assign tick      = (presc == PRESC_LAST);
  assign tcount_wr = wr_stb & (offset == MMIO_TCOUNT);
  assign tcmp_wr   = wr_stb & (offset == MMIO_TCMP);
  // A store to TCOUNT overrides the tick, so it can never raise match itself
  assign match_set = tick & ~tcount_wr & ((tcount + 16'd1) == tcmp);
  assign tcount_rd = tcount;
  assign tcmp_rd   = tcmp;

  // Prescaler, free-running counter and compare register
  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      tcount <= '0;
      tcmp   <= TCMP_RST;
    end else begin
      if (tcount_wr) begin
        tcount <= bus.wr_data;
        presc  <= '0;
      end else if (tick) begin
        tcount <= tcount + 16'd1;
        presc  <= '0;
      end else begin
        presc  <= presc + 1'b1;
      end
      if (tcmp_wr) tcmp <= bus.wr_data;
    end
  end
`else
  assign match_set = 1'b0;
  assign tcount_rd = '0;
  assign tcmp_rd   = '0;
`endif

  mmio_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.wr_data),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  // Count field is 4 bits wide; a 16-deep full FIFO reports 0 here and relies on the full bit
  assign fifo_count_ext = 5'(fifo_count);

  always_comb begin
    status       = '0;
    status.cnt   = fifo_count_ext[3:0];
    status.empty = fifo_empty;
    status.full  = fifo_full;
    status.ovf   = ovf;
    status.match = match;
  end

  // Read mux over current register values, so a same-cycle store is not yet visible
  always_comb begin
    rd_val = '0;
    case (offset)
      MMIO_LED:    rd_val = {{(DATA_W-LED_W){1'b0}}, led_reg};
      MMIO_SW:     rd_val = {{(DATA_W-SW_W){1'b0}}, sw_s2};
      MMIO_TCOUNT: rd_val = tcount_rd;
      MMIO_TCMP:   rd_val = tcmp_rd;
      MMIO_STATUS: rd_val = status;
      default:     rd_val = '0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switches;
      sw_s2 <= sw_s1;
    end
  end

  // LED register and registered load response; rd_data holds between qualified loads
  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg     <= '0;
      bus.rd_data <= '0;
      bus.rd_hit  <= 1'b0;
    end else begin
      if (wr_stb && offset == MMIO_LED) led_reg <= bus.wr_data[LED_W-1:0];
      bus.rd_hit <= rd_stb;
      if (rd_stb) bus.rd_data <= rd_val;
    end
  end

  // Sticky STATUS flags; a set in the same cycle as the read-to-clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf   <= 1'b0;
      match <= 1'b0;
    end else begin
      ovf   <= fifo_drop | (ovf & ~stat_clr);
      match <= match_set | (match & ~stat_clr);
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder (PRESCALE=4, FIFO_DEPTH=4).
// Latency: checks sampled 1 time unit after the active edge.
// Backpressure: tx_ready driven directly by the stimulus sequence.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  switches;
  logic [9:0]  leds;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  int          checks = 0;
  int          errors = 0;

`ifdef MMIO_TIMER_EN
  localparam logic [15:0] EXP_TCMP_RST = 16'hFFFF;
  localparam bit          TIMER_ON     = 1'b1;
`else
  localparam logic [15:0] EXP_TCMP_RST = 16'h0000;
  localparam bit          TIMER_ON     = 1'b0;
`endif

  mmio_responder_if bus();

  mmio_responder #(
    .BASE_ADDR  (16'hFFF0),
    .FIFO_DEPTH (4),
    .PRESCALE   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .leds     (leds),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    bus.addr    = a;
    bus.wr_data = d;
    bus.we      = 1'b1;
    tick();
    bus.we      = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] exp, input string tag);
    bus.addr = a;
    bus.re   = 1'b1;
    #1;
    chk({tag, "_hit"}, 32'(bus.hit), 32'd1);
    tick();
    bus.re = 1'b0;
    chk({tag, "_rd_hit"}, 32'(bus.rd_hit), 32'd1);
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    bus.addr    = 16'h0000;
    bus.wr_data = 16'h0000;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    switches    = 10'h2A5;
    tx_ready    = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_rd_hit",   32'(bus.rd_hit),  32'd0);
    chk("rst_rd_data",  32'(bus.rd_data), 32'd0);
    chk("rst_leds",     32'(leds),        32'd0);
    chk("rst_tx_valid", 32'(tx_valid),    32'd0);
    chk("rst_tx_data",  32'(tx_data),     32'd0);
    reset = 1'b0;

    // Register map after reset; TCOUNT read at the first edge out of reset
    load(16'hFFF2, 16'h0000, "rd_tcount0");
    load(16'hFFF3, EXP_TCMP_RST, "rd_tcmp0");
    load(16'hFFF4, 16'h0008, "rd_status0");
    load(16'hFFF0, 16'h0000, "rd_led0");
    load(16'hFFF1, 16'h02A5, "rd_sw0");
    load(16'hFFF5, 16'h0000, "rd_txdata0");
    store(16'hFFF6, 16'hBEEF);
    load(16'hFFF6, 16'h0000, "rd_off6");

    // LED store masks to 10 bits
    store(16'hFFF0, 16'hFFFF);
    chk("leds_3ff", 32'(leds), 32'h3FF);
    load(16'hFFF0, 16'h03FF, "rd_led1");

    // Out-of-window load: no hit, rd_data holds
    bus.addr = 16'h1234;
    bus.re   = 1'b1;
    #1;
    chk("miss_hit", 32'(bus.hit), 32'd0);
    tick();
    bus.re = 1'b0;
    chk("miss_rd_hit",  32'(bus.rd_hit),  32'd0);
    chk("miss_rd_hold", 32'(bus.rd_data), 32'h03FF);

    // Store and load together: read returns the pre-store value
    bus.addr    = 16'hFFF0;
    bus.wr_data = 16'h0055;
    bus.we      = 1'b1;
    bus.re      = 1'b1;
    tick();
    bus.we = 1'b0;
    bus.re = 1'b0;
    chk("wr_rd_old",    32'(bus.rd_data), 32'h03FF);
    chk("wr_rd_rd_hit", 32'(bus.rd_hit),  32'd1);
    chk("wr_rd_leds",   32'(leds),        32'h055);

    // Timer: TCMP=3, TCOUNT=0 -> ticks at +4,+8,+12 edges, match at +12.
    // Load at +12 collides with the set (set wins), so it reads 0 and +13 reads 1.
    store(16'hFFF3, 16'h0003);
    store(16'hFFF2, 16'h0000);
    repeat (11) tick();
    load(16'hFFF4, 16'h0008, "tmr_status_e12");
    load(16'hFFF4, TIMER_ON ? 16'h0009 : 16'h0008, "tmr_status_e13");
    load(16'hFFF4, 16'h0008, "tmr_status_clr");
    load(16'hFFF2, TIMER_ON ? 16'h0003 : 16'h0000, "tmr_tcount");
    load(16'hFFF3, TIMER_ON ? 16'h0003 : 16'h0000, "tmr_tcmp");

    // Five pushes into a 4-deep FIFO with no consumer
    store(16'hFFF5, 16'h00A1);
    chk("push_tx_valid", 32'(tx_valid), 32'd1);
    chk("push_tx_data",  32'(tx_data),  32'h00A1);
    for (int i = 2; i <= 5; i++) store(16'hFFF5, 16'(16'h00A0 + i));
    load(16'hFFF4, 16'h0046, "ovf_status");
    load(16'hFFF4, 16'h0044, "ovf_cleared");

    // Drain one per cycle in order
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(tx_valid), 32'd1);
      chk("drain_data",  32'(tx_data),  32'(16'h00A0 + i));
      tick();
    end
    tx_ready = 1'b0;
    chk("drain_empty", 32'(tx_valid), 32'd0);

    // Full FIFO: push and pop in one cycle keeps count 4 and no overflow
    for (int i = 1; i <= 4; i++) store(16'hFFF5, 16'(16'h00B0 + i));
    tx_ready = 1'b1;
    store(16'hFFF5, 16'h00B5);
    tx_ready = 1'b0;
    load(16'hFFF4, 16'h0044, "pushpop_status");
    chk("pushpop_head", 32'(tx_data), 32'h00B2);

    // Leave three entries queued, then reset mid-operation
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("three_head", 32'(tx_data), 32'h00B3);
    reset = 1'b1;
    tick();
    chk("mid_rst_tx_valid", 32'(tx_valid),    32'd0);
    chk("mid_rst_tx_data",  32'(tx_data),     32'd0);
    chk("mid_rst_leds",     32'(leds),        32'd0);
    chk("mid_rst_rd_hit",   32'(bus.rd_hit),  32'd0);
    chk("mid_rst_rd_data",  32'(bus.rd_data), 32'd0);
    reset = 1'b0;
    load(16'hFFF2, 16'h0000, "post_rst_tcount");
    load(16'hFFF3, EXP_TCMP_RST, "post_rst_tcmp");
    load(16'hFFF4, 16'h0008, "post_rst_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
